// File: rtl/cut_bist_sequencer.sv
// cut_bist_sequencer: LFSR-driven self-test of a combinational CUT with MISR compaction and golden compare.
// Optional AGING_GUARDBAND_EN adds an early-sample register and a saturating guard_err counter.
module cut_bist_sequencer #(
  parameter int IN_W = 41,
  parameter int OUT_W = 32,
  parameter int NUM_VEC = 31,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W = 16,
  parameter logic [IN_W-1:0] LFSR_TAPS = 41'h100_0000_0004,
  parameter logic [OUT_W-1:0] MISR_TAPS = 32'h8020_0003,
  parameter logic [IN_W-1:0] LFSR_SEED = 41'h1
`ifdef AGING_GUARDBAND_EN
  , parameter int EARLY_CYC = 0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] vec_idx
`ifdef AGING_GUARDBAND_EN
  , output logic [CNT_W-1:0] guard_err
`endif
);
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] settle_cnt;
  logic [IN_W-1:0] lfsr, seed_reg;
  logic last_vec, go, run_abort;
  assign last_vec = vec_idx == CNT_W'(NUM_VEC - 1);
  assign go = state == IDLE && start && !seed_load;
  assign run_abort = abort && state != IDLE;
  assign busy = state == APPLY || state == SETTLE || state == CAPTURE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? APPLY : IDLE;
      APPLY:   state_nx = SETTLE;
      SETTLE:  state_nx = settle_cnt == '0 ? CAPTURE : SETTLE;
      CAPTURE: state_nx = last_vec ? DONE : APPLY;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cut_in <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      signature <= '0;
      vec_idx <= '0;
      lfsr <= '0;
      seed_reg <= LFSR_SEED;
      settle_cnt <= '0;
    end else begin
      state <= state_nx;
      done <= state == DONE && !abort;
      if (run_abort) pass <= 1'b0;
      else begin
        case (state)
          IDLE: begin
            // seed_load wins over start; an all-zero seed would lock the LFSR
            if (seed_load) seed_reg <= seed == '0 ? IN_W'(1) : seed;
            else if (start) begin
              lfsr <= seed_reg;
              signature <= '0;
              vec_idx <= '0;
              pass <= 1'b0;
            end
          end
          APPLY: begin
            cut_in <= lfsr;
            settle_cnt <= CNT_W'(SETTLE_CYC - 1);
          end
          SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
          CAPTURE: begin
            signature <= {signature[OUT_W-2:0], ^(signature & MISR_TAPS)} ^ cut_out;
            lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
            if (!last_vec) vec_idx <= vec_idx + 1'b1;
          end
          DONE: pass <= signature == golden_sig;
          default: ;
        endcase
      end
    end
  end
`ifdef AGING_GUARDBAND_EN
  logic [OUT_W-1:0] early;
  // a path that still changes after the early sample counts as timing-degraded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early <= '0;
      guard_err <= '0;
    end else if (!run_abort) begin
      if (go) guard_err <= '0;
      if (state == SETTLE && settle_cnt == CNT_W'(SETTLE_CYC - 1 - EARLY_CYC)) early <= cut_out;
      if (state == CAPTURE && early != cut_out && guard_err != '1) guard_err <= guard_err + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cut_bist_sequencer.sv
// tb_cut_bist_sequencer: randomized checks of three sequencer instances (1, 2, 31 vectors) against a behavioural model.
module tb_cut_bist_sequencer;
  logic clk, rst_n, start, abort, seed_load;
  logic [40:0] seed;
  logic [31:0] golden;
  logic [40:0] ci [3];
  logic [31:0] sg [3];
  logic [15:0] vi [3];
  logic bz [3], dn [3], ps [3];
  int nvs [3] = '{1, 2, 31};
  int total = 0, bad = 0;
  logic [40:0] mq [$];
  logic [31:0] msig;
`ifdef AGING_GUARDBAND_EN
  logic [15:0] ge [3];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cut_bist_sequencer #(.NUM_VEC(g == 0 ? 1 : g == 1 ? 2 : 31), .SETTLE_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_load(seed_load),
      .seed(seed), .golden_sig(golden), .cut_in(ci[g]), .cut_out(ci[g][31:0]),
      .busy(bz[g]), .done(dn[g]), .pass(ps[g]), .signature(sg[g]), .vec_idx(vi[g])
`ifdef AGING_GUARDBAND_EN
      , .guard_err(ge[g])
`endif
    );
  end

`ifdef AGING_GUARDBAND_EN
  logic [40:0] gci;
  logic [31:0] gsg, gco, d1, d2;
  logic [15:0] gvi, gge;
  logic gbz, gdn, gps, gmode;
  always @(posedge clk) begin
    d1 <= gci[31:0];
    d2 <= d1;
  end
  // slow CUT: vector 1 arrives two cycles late
  assign gco = (gmode && gvi == 16'd1) ? d2 : gci[31:0];
  cut_bist_sequencer #(.NUM_VEC(4), .SETTLE_CYC(3), .EARLY_CYC(0)) gd (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_load(seed_load),
    .seed(seed), .golden_sig(golden), .cut_in(gci), .cut_out(gco),
    .busy(gbz), .done(gdn), .pass(gps), .signature(gsg), .vec_idx(gvi), .guard_err(gge)
  );
`endif

  task automatic model(input logic [40:0] sd, input int n);
    logic [40:0] l;
    l = sd == 41'd0 ? 41'd1 : sd;
    mq.delete();
    msig = 32'd0;
    for (int i = 0; i < n; i++) begin
      mq.push_back(l);
      msig = {msig[30:0], msig[31] ^ msig[21] ^ msig[1] ^ msig[0]} ^ l[31:0];
      l = {l[39:0], l[40] ^ l[2]};
    end
  endtask

  task automatic idle_all();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic run_check(input int k, input logic [40:0] sd, input bit gsel, input logic [31:0] gval);
    int lat;
    idle_all();
    model(sd, nvs[k]);
    golden = gsel ? gval : msig;
    seed = sd;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!dn[k] && lat < 400) begin
      if (lat >= 1 && (lat - 1) % 3 == 0 && (lat - 1) / 3 < nvs[k]) begin
        total++;
        if (ci[k] !== mq[(lat-1)/3] || vi[k] !== 16'((lat - 1) / 3)) begin
          bad++;
          $display("FAIL vector k=%0d i=%0d cut_in=%h vec_idx=%0d want %h %0d", k, (lat-1)/3, ci[k], vi[k], mq[(lat-1)/3], (lat-1)/3);
        end
      end
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 3 * nvs[k] + 1) begin bad++; $display("FAIL latency k=%0d got %0d want %0d", k, lat, 3 * nvs[k] + 1); end
    total++;
    if (sg[k] !== msig) begin bad++; $display("FAIL signature k=%0d got %h want %h", k, sg[k], msig); end
    total++;
    if (ps[k] !== 1'(golden == msig)) begin bad++; $display("FAIL pass k=%0d got %b want %b", k, ps[k], golden == msig); end
    total++;
    if (ci[k] !== mq[nvs[k]-1] || bz[k] !== 1'b0) begin bad++; $display("FAIL end_state k=%0d cut_in=%h busy=%b want %h 0", k, ci[k], bz[k], mq[nvs[k]-1]); end
    @(negedge clk);
    total++;
    if (dn[k] !== 1'b0) begin bad++; $display("FAIL done_pulse k=%0d done still %b want 0", k, dn[k]); end
  endtask

  task automatic test_reset();
    logic [63:0] r;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ci[k], sg[k], vi[k], bz[k], dn[k], ps[k]} !== '0) begin bad++; $display("FAIL reset_vals k=%0d cut_in=%h sig=%h idx=%0d busy=%b done=%b pass=%b want all 0", k, ci[k], sg[k], vi[k], bz[k], dn[k], ps[k]); end
    end
    rst_n = 1'b1;
    run_check(0, 41'd1, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    total++;
    if (ps[0] !== 1'b0 || sg[0] !== 32'd0) begin bad++; $display("FAIL reset_pass got pass=%b sig=%h want 0 0", ps[0], sg[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    r = {$urandom(), $urandom()};
    seed = r[40:0] | 41'h10;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ci[2], sg[2], vi[2], bz[2], dn[2], ps[2]} !== '0) begin bad++; $display("FAIL reset_midrun cut_in=%h sig=%h idx=%0d busy=%b want all 0", ci[2], sg[2], vi[2], bz[2]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bz[2] !== 1'b0) begin bad++; $display("FAIL reset_release busy=%b want 0", bz[2]); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (ci[2] !== 41'd1) begin bad++; $display("FAIL reset_seed cut_in=%h want 1", ci[2]); end
  endtask

  task automatic test_seed_busy();
    logic [63:0] r;
    logic [40:0] a;
    int n;
    idle_all();
    r = {$urandom(), $urandom()};
    a = r[40:0] | 41'h100;
    seed = a;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    seed = ~a;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    n = 0;
    while (!dn[2] && n < 200) begin @(negedge clk); n++; end
    total++;
    if (!dn[2]) begin bad++; $display("FAIL seed_busy_run done=%b want 1", dn[2]); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (ci[2] !== a) begin bad++; $display("FAIL seed_busy cut_in=%h want %h", ci[2], a); end
  endtask

  task automatic test_abort();
    logic [63:0] r;
    logic [31:0] frozen;
    int n, pulses;
    idle_all();
    r = {$urandom(), $urandom()};
    model(r[40:0], 31);
    golden = msig;
    seed = r[40:0];
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vi[2] != 16'd5 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (vi[2] !== 16'd5) begin bad++; $display("FAIL abort_reach vec_idx=%0d want 5", vi[2]); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (bz[2] !== 1'b0 || ps[2] !== 1'b0) begin bad++; $display("FAIL abort_busy busy=%b pass=%b want 0 0", bz[2], ps[2]); end
    frozen = sg[2];
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (dn[2]) pulses++;
    end
    total++;
    if (pulses !== 0 || sg[2] !== frozen) begin bad++; $display("FAIL abort_hold done_pulses=%0d sig=%h want 0 %h", pulses, sg[2], frozen); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (vi[2] !== 16'd0 || sg[2] !== 32'd0) begin bad++; $display("FAIL abort_restart idx=%0d sig=%h want 0 0", vi[2], sg[2]); end
    n = 0;
    while (!dn[2] && n < 200) begin @(negedge clk); n++; end
    total++;
    if (sg[2] !== msig || ps[2] !== 1'b1) begin bad++; $display("FAIL abort_rerun sig=%h pass=%b want %h 1", sg[2], ps[2], msig); end
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom()};
      if ($urandom_range(5) == 0) r = 64'd0;
      run_check($urandom_range(2), r[40:0], 1'($urandom_range(1)), $urandom());
    end
  endtask

`ifdef AGING_GUARDBAND_EN
  task automatic test_guard();
    int n;
    for (int m = 1; m >= 0; m--) begin
      idle_all();
      gmode = 1'(m);
      seed = 41'd1;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!gdn && n < 200) begin @(negedge clk); n++; end
      total++;
      if (gge !== 16'(m) || !gdn) begin bad++; $display("FAIL guard mode=%0d guard_err=%0d done=%b want %0d 1", m, gge, gdn, m); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    golden = '0;
`ifdef AGING_GUARDBAND_EN
    gmode = 1'b0;
`endif
    test_reset();
    run_check(0, 41'd1, 1'b1, 32'h1);
    run_check(1, 41'd1, 1'b1, 32'h2);
    run_check(2, 41'd0, 1'b0, 32'd0);
    test_seed_busy();
    test_abort();
    test_random();
`ifdef AGING_GUARDBAND_EN
    test_guard();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cut_bist_sequencer.md
Name: cut_bist_sequencer

Overview:
- Sequences self-test of a combinational ISCAS85 circuit-under-test (CUT), default c499 (41 in / 32 out), in the aging testbench flow.
- Generates pseudo-random input vectors with an LFSR, drives the CUT, waits a programmable settle time, then compacts each response into a MISR.
- Compares the final signature against a golden value and reports pass/fail with a start/done handshake.
- Replaces file-driven vector application for long aging runs.

Parameters:
- IN_W, 41, CUT input width.
- OUT_W, 32, CUT output width.
- NUM_VEC, 31, vectors applied per run (>=1).
- SETTLE_CYC, 1, cycles between driving cut_in and sampling cut_out (>=1).
- CNT_W, 16, width of vector index and counters.
- LFSR_TAPS, 41'h100_0000_0004, feedback mask (x^41+x^3+1).
- MISR_TAPS, 32'h8020_0003, feedback mask (x^32+x^22+x^2+x+1).
- LFSR_SEED, 41'h1, seed register reset value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without done.
- seed_load  in  1  load seed into seed register; IDLE only.
- seed  in  IN_W  new LFSR seed.
- golden_sig  in  OUT_W  expected final signature.
- cut_in  out  IN_W  registered vector driven to the CUT.
- cut_out  in  OUT_W  CUT response.
- busy  out  1  high in APPLY/SETTLE/CAPTURE.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  signature==golden_sig; held until next start.
- signature  out  OUT_W  current MISR contents.
- vec_idx  out  CNT_W  index of the vector in flight.

Behaviour:
- Reset values: cut_in=0, busy=0, done=0, pass=0, signature=0, vec_idx=0, lfsr=0, seed_reg=LFSR_SEED, FSM=IDLE.
- seed_load in IDLE: seed_reg<=seed. If seed==0, load 1 instead (all-zero lock-up forbidden). Ignored outside IDLE.
- IDLE: on start, lfsr<=seed_reg, signature<=0, vec_idx<=0, pass<=0, go to APPLY. If start and seed_load are both high, the load takes priority and start is ignored that cycle.
- APPLY (1 cycle): cut_in<=lfsr; settle counter<=SETTLE_CYC-1; go to SETTLE.
- SETTLE (SETTLE_CYC cycles): decrement the counter; at 0 go to CAPTURE.
- CAPTURE (1 cycle):
  - signature <= {signature[OUT_W-2:0], ^(signature & MISR_TAPS)} ^ cut_out.
  - lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - If vec_idx==NUM_VEC-1, go to DONE; else vec_idx++ and go to APPLY.
- DONE (1 cycle): done=1, pass<=(signature==golden_sig), go to IDLE.
- Latency: done is high N*(SETTLE_CYC+2)+1 edges after the edge that sampled start, where N=NUM_VEC.
- cut_in holds its last vector after a run and after abort.
- start while busy: ignored, no queuing.
- abort (any non-IDLE state): next state IDLE; busy=0; done not pulsed; pass=0; signature frozen. abort has priority over every transition. abort in IDLE has no effect.
- Reset mid-run: immediate return to reset values; seed_reg also returns to LFSR_SEED.
- golden_sig is sampled only in DONE.

Optional Feature:
- Macro AGING_GUARDBAND_EN.
- Defined:
  - Extra parameter EARLY_CYC (default 0, must be < SETTLE_CYC) and extra output guard_err (CNT_W).
  - During SETTLE, cut_out is sampled into an early register on the cycle the counter equals SETTLE_CYC-1-EARLY_CYC.
  - In CAPTURE, if early != cut_out, guard_err increments, saturating at all-ones.
  - guard_err clears on start and on reset; it is held on abort.
  - Purpose: flag timing-degraded (aged) paths.
- Undefined: no early register, no guard_err port. All other behaviour identical.

Test Plan:
- Bench CUT model: cut_out=cut_in[31:0].
- Reset check: assert rst_n=0 mid-SETTLE -> all outputs read reset values in the same cycle; after release, FSM is IDLE and busy=0.
- Single vector: NUM_VEC=1, SETTLE_CYC=1, seed_load seed=1, then start -> cut_in=41'h1; signature=32'h1; done pulses exactly 4 edges after start; golden_sig=1 gives pass=1.
- Two vectors: NUM_VEC=2, seed=1 -> cut_in sequence 1 then 2; final signature=32'h1; golden_sig=32'h2 gives pass=0; vec_idx reads 0 then 1.
- Zero seed: seed_load seed=0 then start -> first cut_in=41'h1. seed_load while busy -> seed_reg unchanged.
- Abort: NUM_VEC=31, abort during vector 5 -> busy=0 next cycle, done never pulses, pass=0. A new start restarts with vec_idx=0 and signature=0.
- Guardband (AGING_GUARDBAND_EN, SETTLE_CYC=3, EARLY_CYC=0): CUT model delays one vector by 2 cycles -> guard_err=1; an ideal CUT gives guard_err=0.
